// File: rtl/tl_ram_slave.sv
// TileLink-UL RAM slave: single-entry response register, one-cycle latency, byte-masked writes.
// Optional TL_RAM_DENY_EN rejects unsupported opcodes, oversize and misaligned requests.
`timescale 1ns/1ps
module tl_ram_slave #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [2:0]  auto_in_a_bits_size,
   input  logic [5:0]  auto_in_a_bits_source,
   input  logic [12:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,
   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_param,
   output logic [2:0]  auto_in_d_bits_size,
   output logic [5:0]  auto_in_d_bits_source,
   output logic        auto_in_d_bits_sink,
   output logic        auto_in_d_bits_denied,
   output logic [63:0] auto_in_d_bits_data,
   output logic        auto_in_d_bits_corrupt
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [2:0] D_ACK      = 3'd0;
   localparam logic [2:0] D_ACK_DATA = 3'd1;
   localparam logic [2:0] D_HINT_ACK = 3'd2;

   logic             d_valid_reg;
   logic [2:0]       d_opcode_reg;
   logic [2:0]       d_size_reg;
   logic [5:0]       d_source_reg;
   logic             d_denied_reg;
   logic [63:0]      d_data_reg;
   logic             d_corrupt_reg;

   logic [2:0]       d_opcode_next;
   logic             d_denied_next;
   logic [63:0]      d_data_next;
   logic             d_corrupt_next;

   logic             a_fire;
   logic             d_fire;
   logic             wr_en;
   logic             deny;
   logic             is_put;
   logic             is_get;
   logic             is_hint;
   logic [IDX_W-1:0] a_index;
   logic [63:0]      rd_word;
   logic             unused_inputs;

   assign auto_in_a_ready = !d_valid_reg | auto_in_d_ready;
   assign a_fire          = auto_in_a_valid & auto_in_a_ready;
   assign d_fire          = d_valid_reg & auto_in_d_ready;
   assign a_index         = auto_in_a_bits_address[3 +: IDX_W];
   assign unused_inputs   = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt, auto_in_a_bits_address};

   assign is_put  = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
   assign is_get  = (auto_in_a_bits_opcode == 3'd2) || (auto_in_a_bits_opcode == 3'd3) ||
                    (auto_in_a_bits_opcode == 3'd4);
   assign is_hint = (auto_in_a_bits_opcode == 3'd5);

`ifdef TL_RAM_DENY_EN
   logic misaligned;
   assign misaligned = (auto_in_a_bits_address &
                        ((13'd1 << auto_in_a_bits_size) - 13'd1)) != 13'd0;
   // Only PutFull, PutPartial and plain Get (4) are served; everything else is refused.
   assign deny = !(is_put || (auto_in_a_bits_opcode == 3'd4)) ||
                 (auto_in_a_bits_size > 3'd3) || misaligned;
`else
   assign deny = 1'b0;
`endif

   always_comb begin
      d_opcode_next  = D_ACK;
      d_denied_next  = 1'b0;
      d_data_next    = 64'd0;
      d_corrupt_next = 1'b0;
      wr_en          = 1'b0;
      if (deny) begin
         d_denied_next = 1'b1;
         if (is_get) begin
            d_opcode_next  = D_ACK_DATA;
            d_corrupt_next = 1'b1;
         end else if (is_hint) begin
            d_opcode_next = D_HINT_ACK;
         end
      end else if (is_put) begin
         wr_en = a_fire & !reset;
      end else if (is_get) begin
         d_opcode_next = D_ACK_DATA;
         d_data_next   = rd_word;
      end else if (is_hint) begin
         d_opcode_next = D_HINT_ACK;
      end
   end

   // One narrow array per byte lane keeps the masked write a plain single-writer RAM.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         always_ff @(posedge clock) begin
            if (wr_en && auto_in_a_bits_mask[gi]) begin
               lane_mem[a_index] <= auto_in_a_bits_data[gi*8 +: 8];
            end
         end
         assign rd_word[gi*8 +: 8] = lane_mem[a_index];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         d_valid_reg   <= 1'b0;
         d_opcode_reg  <= 3'd0;
         d_size_reg    <= 3'd0;
         d_source_reg  <= 6'd0;
         d_denied_reg  <= 1'b0;
         d_data_reg    <= 64'd0;
         d_corrupt_reg <= 1'b0;
      end else if (a_fire) begin
         d_valid_reg   <= 1'b1;
         d_opcode_reg  <= d_opcode_next;
         d_size_reg    <= auto_in_a_bits_size;
         d_source_reg  <= auto_in_a_bits_source;
         d_denied_reg  <= d_denied_next;
         d_data_reg    <= d_data_next;
         d_corrupt_reg <= d_corrupt_next;
      end else if (d_fire) begin
         d_valid_reg <= 1'b0;
      end
   end

   assign auto_in_d_valid        = d_valid_reg;
   assign auto_in_d_bits_opcode  = d_opcode_reg;
   assign auto_in_d_bits_param   = 2'd0;
   assign auto_in_d_bits_size    = d_size_reg;
   assign auto_in_d_bits_source  = d_source_reg;
   assign auto_in_d_bits_sink    = 1'b0;
   assign auto_in_d_bits_denied  = d_denied_reg;
   assign auto_in_d_bits_data    = d_data_reg;
   assign auto_in_d_bits_corrupt = d_corrupt_reg;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Scoreboard bench for tl_ram_slave: driver pushes model responses at A fire, monitor checks D.
`timescale 1ns/1ps
module tb_tl_ram_slave;
   localparam int DEPTH = 16;

   typedef struct {
      logic [2:0]  opcode;
      logic [2:0]  size;
      logic [5:0]  source;
      logic        denied;
      logic [63:0] data;
      logic        corrupt;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_ready;
   logic        a_valid = 1'b0;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_param = '0;
   logic [2:0]  a_size = '0;
   logic [5:0]  a_source = '0;
   logic [12:0] a_address = '0;
   logic [7:0]  a_mask = '0;
   logic [63:0] a_data = '0;
   logic        a_corrupt = 1'b0;
   logic        d_ready = 1'b1;
   logic        d_valid;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [2:0]  d_size;
   logic [5:0]  d_source;
   logic        d_sink;
   logic        d_denied;
   logic [63:0] d_data;
   logic        d_corrupt;

   int          n_vec = 0;
   int          n_err = 0;
   rsp_t        exp_q[$];
   logic [63:0] model_mem [DEPTH];
   logic        last_fired;

   always #5 clk = ~clk;

   tl_ram_slave #(.DEPTH_WORDS(DEPTH)) dut (
      .clock(clk), .reset(reset),
      .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
      .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
      .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
      .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
      .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
      .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
      .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_param(d_param),
      .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_source),
      .auto_in_d_bits_sink(d_sink), .auto_in_d_bits_denied(d_denied),
      .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: what a TileLink RAM must answer, and its effect on storage.
   function automatic rsp_t model_access(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [5:0] src, input logic [12:0] addr,
                                         input logic [7:0] mask, input logic [63:0] data);
      rsp_t r;
      int   idx;
      bit   refused;
      idx       = (int'(addr) / 8) % DEPTH;
      r.opcode  = 3'd0;
      r.size    = sz;
      r.source  = src;
      r.denied  = 1'b0;
      r.data    = 64'd0;
      r.corrupt = 1'b0;
      refused   = 1'b0;
`ifdef TL_RAM_DENY_EN
      refused = !(op == 0 || op == 1 || op == 4) || sz > 3 || (int'(addr) % (1 << sz)) != 0;
`endif
      if (refused) begin
         r.denied = 1'b1;
         if (op >= 2 && op <= 4) begin
            r.opcode  = 3'd1;
            r.corrupt = 1'b1;
         end else if (op == 5) begin
            r.opcode = 3'd2;
         end
      end else begin
         case (op)
            3'd0, 3'd1: begin
               for (int b = 0; b < 8; b++)
                  if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            end
            3'd2, 3'd3, 3'd4: begin
               r.opcode = 3'd1;
               r.data   = model_mem[idx];
            end
            3'd5: r.opcode = 3'd2;
            default: r.opcode = 3'd0;
         endcase
      end
      return r;
   endfunction

   // One clock of stimulus; the expected response is queued if A fires at the coming edge.
   task automatic cycle(input logic av, input logic [2:0] op, input logic [2:0] sz,
                        input logic [12:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic dr);
      @(posedge clk);
      #1;
      a_valid   = av;
      a_opcode  = op;
      a_size    = sz;
      a_source  = 6'($urandom_range(0, 63));
      a_address = addr;
      a_mask    = mask;
      a_data    = data;
      a_param   = 3'($urandom_range(0, 7));
      a_corrupt = 1'($urandom_range(0, 1));
      d_ready   = dr;
      @(negedge clk);
      #1;
      last_fired = av && a_ready && !reset;
      if (last_fired) exp_q.push_back(model_access(op, sz, a_source, addr, mask, data));
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [12:0] addr,
                        input logic [7:0] mask, input logic [63:0] data);
      int budget;
      budget = 0;
      do begin
         cycle(1'b1, op, sz, addr, mask, data, 1'b1);
         budget++;
      end while (!last_fired && budget < 20);
      if (!last_fired) check("a_fire_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         reset   = 1'b1;
         a_valid = 1'b0;
         @(negedge clk);
         #1;
         exp_q.delete();
         if (i > 0) begin
            check("rst_d_valid", 64'(d_valid), 64'd0);
            check("rst_fields", {d_opcode, d_size, d_source, d_denied, d_corrupt}, 64'd0);
            check("rst_data", d_data, 64'd0);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: D must be valid exactly while a response is owed and must match the queue head.
   always @(negedge clk) begin
      check("d_valid", 64'(d_valid), 64'(exp_q.size() > 0));
      check("a_ready", 64'(a_ready), 64'((exp_q.size() == 0) || d_ready));
      check("d_consts", {d_param, d_sink}, 64'd0);
      if (d_valid && exp_q.size() > 0) begin
         check("d_opcode", 64'(d_opcode), 64'(exp_q[0].opcode));
         check("d_size", 64'(d_size), 64'(exp_q[0].size));
         check("d_source", 64'(d_source), 64'(exp_q[0].source));
         check("d_denied", 64'(d_denied), 64'(exp_q[0].denied));
         check("d_corrupt", 64'(d_corrupt), 64'(exp_q[0].corrupt));
         check("d_data", d_data, exp_q[0].data);
         if (d_ready) begin
            $display("D src=%0d op=%0d den=%0d data=%h", d_source, d_opcode, d_denied, d_data);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int streamed;
      do_reset(3);
      check("a_ready_after_reset", 64'(a_ready), 64'd1);

      for (int i = 0; i < DEPTH; i++)
         issue(3'd0, 3'd3, 13'(i * 8), 8'hFF, {$urandom, $urandom});

      issue(3'd0, 3'd3, 13'h010, 8'hFF, 64'h1122334455667788);
      issue(3'd4, 3'd3, 13'h010, 8'h00, 64'd0);
      issue(3'd1, 3'd3, 13'h010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
      issue(3'd4, 3'd3, 13'h010, 8'h00, 64'd0);
      cycle(1'b0, 3'd0, 3'd0, 13'h0, 8'h0, 64'd0, 1'b1);

      // Stall D for five cycles with another Get waiting, then stream Gets.
      cycle(1'b1, 3'd4, 3'd3, 13'h010, 8'h00, 64'd0, 1'b0);
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 3'd4, 3'd3, 13'h018, 8'h00, 64'd0, 1'b0);
      streamed = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 3'd4, 3'd3, 13'($urandom_range(0, DEPTH - 1) * 8), 8'h00, 64'd0, 1'b1);
         if (last_fired) streamed++;
      end
      check("stream_rate", 64'(streamed), 64'd8);
      cycle(1'b0, 3'd0, 3'd0, 13'h0, 8'h0, 64'd0, 1'b1);

      // Reset with a response pending; storage must survive it.
      cycle(1'b1, 3'd4, 3'd3, 13'h008, 8'h00, 64'd0, 1'b0);
      cycle(1'b0, 3'd0, 3'd0, 13'h0, 8'h0, 64'd0, 1'b0);
      do_reset(2);
      issue(3'd4, 3'd3, 13'h010, 8'h00, 64'd0);
      issue(3'd4, 3'd3, 13'h004, 8'h00, 64'd0);
      issue(3'd5, 3'd0, 13'h020, 8'h00, 64'd0);
      issue(3'd6, 3'd0, 13'h020, 8'hFF, 64'hDEAD);
      issue(3'd2, 3'd3, 13'h1FF8, 8'h00, 64'd0);

      for (int i = 0; i < 600; i++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1) * 4);
         cycle(1'($urandom_range(0, 3) != 0), op, 3'($urandom_range(0, 7)),
               13'($urandom), 8'($urandom), {$urandom, $urandom},
               1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 3'd0, 13'h0, 8'h0, 64'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tl_ram_slave.md
TL_RAM_SLAVE -- requirements
Module: tl_ram_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 64-bit words stored; legal range 2..1024, power of two.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 auto_in_a_ready  out  1  A-channel ready.
REQ-005 auto_in_a_valid  in  1  A-channel valid.
REQ-006 auto_in_a_bits_opcode  in  3  0 PutFullData, 1 PutPartialData, 4 Get.
REQ-007 auto_in_a_bits_param  in  3  ignored.
REQ-008 auto_in_a_bits_size  in  3  log2 bytes.
REQ-009 auto_in_a_bits_source  in  6  requester ID.
REQ-010 auto_in_a_bits_address  in  13  byte address.
REQ-011 auto_in_a_bits_mask  in  8  byte-lane write enables.
REQ-012 auto_in_a_bits_data  in  64  write data.
REQ-013 auto_in_a_bits_corrupt  in  1  ignored.
REQ-014 auto_in_d_ready  in  1  D-channel ready.
REQ-015 auto_in_d_valid  out  1  D-channel valid.
REQ-016 auto_in_d_bits_opcode  out  3  0 AccessAck, 1 AccessAckData, 2 HintAck.
REQ-017 auto_in_d_bits_param  out  2  constant 0.
REQ-018 auto_in_d_bits_size  out  3  echo of request size.
REQ-019 auto_in_d_bits_source  out  6  echo of request source.
REQ-020 auto_in_d_bits_sink  out  1  constant 0.
REQ-021 auto_in_d_bits_denied  out  1  request rejected.
REQ-022 auto_in_d_bits_data  out  64  read data.
REQ-023 auto_in_d_bits_corrupt  out  1  read data invalid.

Function
REQ-024 Single-entry response register (valid, opcode, size, source, denied, data, corrupt); A fires on a_valid & a_ready; a_ready = !d_valid | d_ready (combinational, full throughput, one response per cycle).
REQ-025 Latency exactly 1: request fired in cycle N yields d_valid in N+1; d_valid clears after a D fire with no A fire in the same cycle.
REQ-026 Simultaneous D fire and A fire: register reloads with the new response; d_valid stays 1.
REQ-027 While d_valid & !d_ready, all auto_in_d_* outputs held stable.
REQ-028 Word index = address[12:3] modulo DEPTH_WORDS; address bits above the index range are ignored.
REQ-029 Get: register captures mem[index] at fire; opcode 1; data is pre-write array contents.
REQ-030 PutFullData/PutPartialData: at fire edge, bytes of mem[index] whose mask bit is 1 take a_data bytes; opcode 0, data 0.
REQ-031 Back-to-back Put then Get to same index: Get returns the new data.
REQ-032 denied = 0 and corrupt = 0 unless REQ-036 applies.
REQ-033 Opcodes 2/3 are treated as Get with no write; opcode 5 produces HintAck with no access; opcodes 6/7 produce AccessAck with no write.

Reset
REQ-034 While reset is high at a clock edge: d_valid = 0, response register fields = 0, and no A fire is counted; a_ready = 1 after reset deasserts.
REQ-035 Reset mid-operation drops any pending response; writes committed before reset persist; memory array is never reset.

Configuration
REQ-036 With TL_RAM_DENY_EN defined: opcodes 2, 3, 5, 6 and 7, size > 3, or an address not aligned to 2^size → no write, denied = 1; Get-class → opcode 1, data 0, corrupt = 1; 5 → HintAck; otherwise AccessAck.
REQ-037 With TL_RAM_DENY_EN undefined: denied and corrupt are constant 0, and REQ-033 applies without alignment or size checks.

Verification
REQ-038 Put opcode 0, address 0x010, mask 0xFF, data 0x1122334455667788, then Get at 0x010 → D opcode 1, data 0x1122334455667788, one cycle after each fire.
REQ-039 PutPartial opcode 1, address 0x010, mask 0x0F, data 0xAAAAAAAA_BBBBBBBB, then Get → data 0x11223344_BBBBBBBB.
REQ-040 d_ready held 0 for 5 cycles with a Get pending → a_ready = 0 and D fields stable; on release, streaming Gets complete 1 per cycle.
REQ-041 Reset asserted while d_valid = 1 → d_valid = 0 on the next cycle; after reset, Get at 0x010 returns the pre-reset written data.
REQ-042 With TL_RAM_DENY_EN defined, Get with size 3 at address 0x004 → denied = 1, corrupt = 1, data 0; without the macro → data from index 0, denied = 0.
